vram_byte_sequencer: RTL

Parametrised video-RAM byte sequencer between the CRTC/Gate-Array timing and the 8·BYTES-bit VRAM port. It computes the VRAM word address from the CRTC MA/RA outputs and issues one byte per CAS pulse to the Gate Array, modelling BYTES consecutive 8-bit fetches inside one video RAS cycle. An optional one-byte delay path realigns pixel data when the CRT sync filter shifts the picture, blanking the carried-over byte outside display enable. It generalises the fixed two-byte fetch logic of the motherboard to 2–4 bytes per word.

---
 rtl/vram_byte_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vram_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vram_byte_sequencer
// Purpose  : Video-RAM byte sequencer between CRTC/Gate-Array timing and a
//            BYTES-wide VRAM port. Builds the VRAM word address from CRTC
//            MA/RA and hands one byte per CAS pulse to the Gate Array,
//            modelling BYTES consecutive 8-bit fetches per video RAS cycle.
//            Optional one-byte delay path (macro VRAM_SHIFT_EN) realigns
//            pixel data when the sync filter shifts the picture; the
//            carried-over byte is blanked outside display enable.
// Params   : BYTES - bytes per VRAM word (2, 3 or 4)
//            DW    - VRAM data width, 8*BYTES (derived)
// Ports    : clk, reset (sync, active high)
//            cpu_n      - CPU slot strobe, low = CPU owns RAM
//            ras_n/cas_n- Gate Array RAS/CAS, active low
//            crtc_ma/ra - CRTC memory / raster address
//            de         - CRTC display enable
//            shift_en   - select one-byte delay path (VRAM_SHIFT_EN only)
//            vram_din   - VRAM read word, byte k = vram_din[8k+7:8k]
//            vram_addr  - registered VRAM word address
//            vram_d     - registered byte to Gate Array
//            byte_idx   - index of byte currently presented
// Revision : 1.0 - initial release
// ============================================================================
module vram_byte_sequencer #(
    parameter int BYTES = 2,
    parameter int DW    = 8 * BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_n,
    input  logic          ras_n,
    input  logic          cas_n,
    input  logic [13:0]   crtc_ma,
    input  logic [4:0]    crtc_ra,
    input  logic          de,
    input  logic          shift_en,
    input  logic [DW-1:0] vram_din,
    output logic [14:0]   vram_addr,
    output logic [7:0]    vram_d,
    output logic [1:0]    byte_idx
);

    localparam logic [1:0] c_last_idx = 2'(BYTES - 1);

    // Byte lanes padded to four entries so a 2-bit index never leaves the
    // array; padding lanes are unreachable because byte_idx wraps at BYTES-1.
    logic [7:0] w_bytes [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_bytes
            if (g < BYTES) begin : g_lane
                assign w_bytes[g] = vram_din[8*g +: 8];
            end else begin : g_pad
                assign w_bytes[g] = 8'h00;
            end
        end
    endgenerate

    logic       r_cas_n_old;
    logic       w_capture;
    logic       w_release;
    logic [1:0] w_idx_next;
    logic [7:0] w_capture_byte;

    // Capture while CAS is low; advance on the CAS rising edge. The two are
    // mutually exclusive because they need opposite cas_n levels.
    assign w_capture  = ~ras_n & ~cas_n & cpu_n;
    assign w_release  = ~ras_n & ~r_cas_n_old & cas_n & cpu_n;
    assign w_idx_next = (byte_idx == c_last_idx) ? 2'd0 : byte_idx + 2'd1;

`ifdef VRAM_SHIFT_EN
    logic [7:0] r_hold;
    logic       w_hold_load;

    assign w_hold_load = w_capture & shift_en & (byte_idx == c_last_idx);

    // Delayed path: byte 0 slot shows the last byte of the previous word.
    always_comb begin
        w_capture_byte = w_bytes[byte_idx];
        if (shift_en) begin
            w_capture_byte = (byte_idx == 2'd0) ? r_hold : w_bytes[byte_idx - 2'd1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= 8'h00;
        end else if (w_hold_load) begin
            // Carried byte is blanked when it falls outside display enable.
            r_hold <= de ? w_bytes[c_last_idx] : 8'h00;
        end
    end
`else
    logic w_unused_shift;

    assign w_capture_byte = w_bytes[byte_idx];
    assign w_unused_shift = &{1'b0, shift_en, de};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vram_addr   <= 15'h0000;
            vram_d      <= 8'h00;
            byte_idx    <= 2'd0;
            r_cas_n_old <= 1'b1;
        end else begin
            r_cas_n_old <= cas_n;
            if (cpu_n) begin
                vram_addr <= {crtc_ma[13:12], crtc_ra[2:0], crtc_ma[9:0]};
                if (w_release) begin
                    byte_idx <= w_idx_next;
                end
                if (w_capture) begin
                    vram_d <= w_capture_byte;
                end
            end else begin
                // CPU slot: restart the word, keep address and data.
                byte_idx <= 2'd0;
            end
        end
    end

endmodule
`default_nettype wire
